// File: rtl/delay_pkg.sv
// Shared types and default sizing for the inertial filter and its width meter.
package delay_pkg;
   typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_e;

   localparam int DELAY_DEF = 5;
   localparam int CW_DEF    = 8;
endpackage

// File: rtl/inertial_filter_width_meter.sv
// Measures how long each filtered level lasted and presents it on a
// valid/ready holding register; a new measurement arriving while one is held is dropped.
module width_meter
   import delay_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          chg_i,
   input  logic          ready_i,
   output logic          valid_o,
   output logic [CW-1:0] width_o,
   output logic          overrun_o
);
   localparam logic [CW-1:0] SAT = '1;

   logic [CW-1:0] lvl_q, lvl_d;
   logic [CW-1:0] width_q, width_d;
   logic          vld_q, vld_d;
   logic          ovr_q, ovr_d;
   logic          accept;

   assign accept = vld_q & ready_i;

   always_comb begin
      lvl_d   = (lvl_q == SAT) ? lvl_q : lvl_q + 1'b1;
      width_d = width_q;
      vld_d   = vld_q & ~accept;
      ovr_d   = 1'b0;
      if (chg_i) begin
         lvl_d = {{(CW-1){1'b0}}, 1'b1};
         // an acceptance on the same edge frees the slot for the new value
         if (!vld_q || accept) begin
            width_d = lvl_q;
            vld_d   = 1'b1;
         end else begin
            ovr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lvl_q   <= '0;
         width_q <= '0;
         vld_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         lvl_q   <= lvl_d;
         width_q <= width_d;
         vld_q   <= vld_d;
         ovr_q   <= ovr_d;
      end
   end

   assign valid_o   = vld_q;
   assign width_o   = width_q;
   assign overrun_o = ovr_q;
endmodule

// File: rtl/inertial_filter.sv
// Inertial (pulse-swallowing) level filter: dout follows din only after DELAY
// consecutive differing samples; abandoned changes pulse glitch.
module inertial_filter
   import delay_pkg::*;
#(
   parameter int DELAY = DELAY_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din,
   output logic          dout,
   output logic          glitch,
   output logic          width_valid,
   output logic [CW-1:0] width,
   input  logic          width_ready,
   output logic          overrun
);
   localparam logic [7:0] DLY_M1 = 8'(DELAY - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       dout_q, dout_d;
   logic       glitch_q, glitch_d;
   logic       chg;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dout_d   = dout_q;
      glitch_d = 1'b0;
      case (state_q)
         STABLE: begin
            if (din != dout_q) begin
               if (DELAY == 1) begin
                  dout_d = din;
               end else begin
                  state_d = PENDING;
                  cnt_d   = 8'd1;
               end
            end
         end
         PENDING: begin
            if (din != dout_q) begin
               if (cnt_q == DLY_M1) begin
                  dout_d  = din;
                  state_d = STABLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end else begin
               state_d  = STABLE;
               cnt_d    = '0;
               glitch_d = 1'b1;
            end
         end
         default: begin
            state_d = STABLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= STABLE;
         cnt_q    <= '0;
         dout_q   <= 1'b0;
         glitch_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         glitch_q <= glitch_d;
      end
   end

   assign chg = dout_d ^ dout_q;

   width_meter #(.CW(CW)) u_meter (
      .clk       (clk),
      .rst       (rst),
      .chg_i     (chg),
      .ready_i   (width_ready),
      .valid_o   (width_valid),
      .width_o   (width),
      .overrun_o (overrun)
   );

   assign dout   = dout_q;
   assign glitch = glitch_q;
endmodule

// File: tb/tb_inertial_filter.sv
// Randomized and directed bench for inertial_filter with a behavioural model
// and a width scoreboard drained by an independent monitor.
module tb_inertial_filter;
   localparam int DELAY = 5;
   localparam int CW    = 8;
   localparam int SAT   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          din = 1'b0;
   logic          width_ready = 1'b0;
   logic          dout, glitch, width_valid, overrun;
   logic [CW-1:0] width;

   int vectors = 0;
   int miscompares = 0;

   // behavioural model state
   bit m_dout, m_glitch, m_ovr, m_vld;
   int run, lvl;
   int wq[$];

   int last_width = -1;
   int gl_count = 0;
   int ovr_count = 0;

   inertial_filter #(.DELAY(DELAY), .CW(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .dout        (dout),
      .glitch      (glitch),
      .width_valid (width_valid),
      .width       (width),
      .width_ready (width_ready),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_dout = 0; m_glitch = 0; m_ovr = 0; m_vld = 0;
      run = 0; lvl = 0;
      wq.delete();
   endtask

   // one sampling edge, using the din/width_ready the DUT just saw
   task automatic model_step();
      bit acc, chg;
      acc = m_vld && width_ready;
      chg = 0;
      m_glitch = 0;
      m_ovr = 0;
      if (din != m_dout) begin
         run++;
         if (run >= DELAY) begin
            chg = 1;
            run = 0;
         end
      end else begin
         if (run > 0) m_glitch = 1;
         run = 0;
      end
      if (chg) begin
         if (!m_vld || acc) begin
            wq.push_back(lvl);
            m_vld = 1;
         end else begin
            m_ovr = 1;
         end
         lvl = 1;
         m_dout = ~m_dout;
      end else begin
         if (acc) m_vld = 0;
         if (lvl < SAT) lvl++;
      end
   endtask

   task automatic cyc(input logic d, input logic r);
      @(posedge clk);
      if (!rst) model_step();
      #2;
      din = d;
      width_ready = r;
   endtask

   task automatic hold(input logic d, input logic r, input int n);
      for (int i = 0; i < n; i++) cyc(d, r);
   endtask

   // monitor: compares per-cycle outputs and drains the width scoreboard
   always @(negedge clk) begin
      chk("dout", dout, m_dout);
      chk("glitch", glitch, m_glitch);
      chk("overrun", overrun, m_ovr);
      chk("width_valid", width_valid, m_vld);
      if (glitch) gl_count++;
      if (overrun) ovr_count++;
      if (width_valid && width_ready) begin
         if (wq.size() == 0) begin
            chk("width_unexpected", int'(width), -1);
         end else begin
            chk("width", int'(width), wq.pop_front());
         end
         last_width = int'(width);
      end
   end

   initial begin
      int g0, o0;
      model_reset();
      hold(1'b0, 1'b1, 3);
      chk("rst_dout", dout, 0);
      chk("rst_width", int'(width), 0);
      @(posedge clk); #2 rst = 1'b0;

      // short pulse swallowed, one glitch
      g0 = gl_count;
      hold(1'b0, 1'b1, 4);
      hold(1'b1, 1'b1, 2);
      hold(1'b0, 1'b1, 6);
      chk("glitch_once", gl_count - g0, 1);

      // 40-cycle high level
      g0 = gl_count;
      hold(1'b1, 1'b1, 40);
      hold(1'b0, 1'b1, 10);
      chk("width_40", last_width, 40);
      chk("no_glitch_long", gl_count - g0, 0);

      // saturation
      hold(1'b1, 1'b1, 300);
      hold(1'b0, 1'b1, 10);
      chk("width_sat", last_width, SAT);

      // overrun with consumer stalled
      o0 = ovr_count;
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 10);
      chk("overrun_once", ovr_count - o0, 1);
      hold(1'b0, 1'b1, 3);

      // reset mid-pending: dout high, valid held, three low samples seen
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 4);
      chk("pre_rst_dout", dout, 1);
      chk("pre_rst_valid", width_valid, 1);
      #3 rst = 1'b1;
      #1;
      chk("async_rst_dout", dout, 0);
      chk("async_rst_glitch", glitch, 0);
      chk("async_rst_valid", width_valid, 0);
      model_reset();
      hold(1'b0, 1'b1, 2);
      @(posedge clk); #2 rst = 1'b0;

      // randomized run-length stimulus with a stuttering consumer
      for (int i = 0; i < 3000; i++) begin
         logic d;
         d = ($urandom_range(0, 3) != 0) ? din : ~din;
         cyc(d, $urandom_range(0, 9) < 7);
      end
      hold(din, 1'b1, 10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/inertial_filter.md
INERTIAL_FILTER -- requirements
Module: inertial_filter

Interface
REQ-001 Parameter DELAY, default 5, sets the consecutive sampled cycles din must differ from dout before dout follows; legal range 1..255.
REQ-002 Parameter CW, default 8, sets the pulse-width counter and width output width in bits.
REQ-003 Port clk, input, 1, the single clock; every flop is rising-edge clk.
REQ-004 Port rst, input, 1, asynchronous active-high reset.
REQ-005 Port din, input, 1, raw level, sampled directly on each clk edge with no synchronizer inside.
REQ-006 Port dout, output, 1, filtered level.
REQ-007 Port glitch, output, 1, one-cycle pulse when a pending change is abandoned.
REQ-008 Port width_valid, output, 1, a measured level width is being presented.
REQ-009 Port width, output, CW, cycles the previous dout level was held, saturating.
REQ-010 Port width_ready, input, 1, consumer accepts width when it is high together with width_valid.
REQ-011 Port overrun, output, 1, one-cycle pulse when a measurement is dropped.

Function
REQ-012 The FSM SHALL have exactly two states: STABLE and PENDING.
REQ-013 In STABLE, if sampled din equals dout, the FSM SHALL stay in STABLE.
REQ-014 In STABLE, if sampled din differs from dout and DELAY>1, the FSM SHALL go to PENDING and set the pending counter to 1.
REQ-015 In PENDING, if din differs from dout and counter < DELAY-1, the FSM SHALL increment the counter and stay in PENDING.
REQ-016 In PENDING, if din differs from dout and counter = DELAY-1, dout SHALL take din and the FSM SHALL go to STABLE.
REQ-017 In PENDING, if din equals dout, the FSM SHALL go to STABLE, clear the counter, and raise glitch for exactly one cycle.
REQ-018 Net effect: dout changes on the DELAY-th consecutive sampling edge where din differs from dout; any shorter excursion is swallowed (inertial behaviour).
REQ-019 With DELAY=1, dout SHALL follow din with one cycle of latency and glitch SHALL never assert.
REQ-020 A level counter SHALL count clk edges since the last dout change, saturating at 2^CW-1 with no wrap.
REQ-021 On each dout change, the level counter SHALL be captured into width, and the counter SHALL restart at 1.
REQ-022 width_valid SHALL set on the edge dout changes, if no measurement is currently held.
REQ-023 width_valid SHALL clear on the edge where width_valid and width_ready are both high.
REQ-024 width SHALL stay stable while width_valid is high and not accepted.
REQ-025 If dout changes while a held measurement is not accepted, the new measurement SHALL be dropped, overrun SHALL pulse for one cycle, and the held value SHALL be kept.
REQ-026 If a dout change and acceptance occur on the same edge, the new value SHALL load and width_valid SHALL stay high; overrun SHALL NOT assert.
REQ-027 The first dout change after reset SHALL report the width counted from reset release.

Reset
REQ-028 While rst is high, state SHALL be STABLE; dout, glitch, width_valid and overrun SHALL be 0; width and both counters SHALL be 0.
REQ-029 rst asserted mid-PENDING SHALL abandon the pending change without pulsing glitch.
REQ-030 Operation SHALL resume on the first clk edge after rst falls.

Structure
REQ-031 The state enumeration, DELAY and CW defaults SHALL live in a shared package, delay_pkg.
REQ-032 The width counter with its capture and valid/ready holding register SHALL be one sub-module, width_meter; the FSM SHALL stay in the top level.

Verification (DELAY=5, CW=8, 10 ns clock)
REQ-033 din 0->1 held 2 cycles, then 0: dout stays 0, and glitch pulses once on the edge din is seen back at 0.
REQ-034 din 0->1 held 10 cycles: dout rises on the 5th sampling edge after din rose, and glitch stays 0.
REQ-035 dout high for 40 cycles then low, width_ready=1: width_valid pulses one cycle with width=40.
REQ-036 dout level lasting 300 cycles: width=255 (saturated).
REQ-037 width_ready=0 and two accepted dout changes: first width held, and overrun pulses once on the second change.
REQ-038 rst asserted at PENDING count 3: dout=0, glitch=0, width_valid=0 immediately, without waiting for clk.
